sm4_key_expand: RTL and testbench
=================================

// Module: sm4_key_expand
// PURPOSE
//  Iterative SM4 key schedule: turns a 128-bit master key into 32 round keys rk0..rk31, one per clock.
//  Drives sm4_round_cnt into SM4_KEY_CKI and consumes the returned sm4_key_cki constant.
//  Stores all round keys in a 32x32 register file.
//  The CTR datapath reads them back by index, in forward (encrypt) or reversed (decrypt) order.
// PARAMETERS
//  None. Width is fixed by SM4: 128-bit key, 32-bit words, 32 rounds.
// PORTS
//  clk_sys        in   1    system clock; single clock domain
//  rst_sys        in   1    synchronous, active-high reset
//  key_in         in   128  master key MK0..MK3, MK0 = [127:96]; sampled with key_start
//  key_start      in   1    pulse: begin expansion (honoured in IDLE/READY only)
//  key_busy       out  1    high while in EXPAND
//  key_ready      out  1    high while round-key file is valid (READY)
//  key_done       out  1    one-cycle pulse on entry to READY
//  sm4_round_cnt  out  5    round index to SM4_KEY_CKI
//  sm4_key_cki    in   32   CK(sm4_round_cnt), combinational from SM4_KEY_CKI
//  rk_rd_en       in   1    round-key read request
//  rk_rd_idx      in   5    logical round index 0..31
//  rk_decrypt     in   1    1: physical index = 31 - rk_rd_idx
//  rk_out         out  32   round key, registered
//  rk_valid       out  1    rk_out qualifier, 1 cycle after rk_rd_en
// BEHAVIOUR
//  Reset: state IDLE; key_busy/key_ready/key_done/rk_valid=0; rk_out=0; sm4_round_cnt=0.
//  FSM: IDLE -key_start-> EXPAND -cnt==31-> READY -key_start-> EXPAND.
//  key_start during EXPAND is ignored; the running expansion completes unchanged.
//  Load (key_start edge): K0..K3 = MK ^ {A3B1BAC6, 56AA3350, 677D9197, B27022DC}; cnt=0; key_ready drops.
//  Per EXPAND cycle with cnt=i:
//    X = K1^K2^K3^sm4_key_cki.
//    B = tau(X), using four sm4_sbox byte instances.
//    rk_i = K0 ^ B ^ (B<<<13) ^ (B<<<23).
//    Write rk_i to file[i]; shift {K0,K1,K2,K3} <= {K1,K2,K3,rk_i}; cnt increments.
//  sm4_round_cnt = cnt register, so CK is combinationally valid in the same cycle.
//  At cnt==31: write rk31, go READY, cnt wraps to 0, key_done=1 for exactly one cycle.
//  Timing: rk0 is written 1 edge after the start edge; key_done is high in the 32nd cycle after that edge.
//  Reads: rk_rd_en sampled at an edge -> rk_out = file[phys] and rk_valid=1 on the next cycle.
//    rk_valid=0 when rk_rd_en=0.
//    A read when key_ready=0 still returns 1 cycle later, with rk_valid=0 and rk_out held.
//  Back-to-back reads: one per cycle.
//  Read in the same cycle as key_start: served from the old contents (read precedes overwrite).
//  Reset mid-EXPAND: aborts to IDLE; the partial file is not marked valid.
// CONFIGURATION
//  SM4_KEY_ZEROIZE_EN defined:
//    Adds input key_zeroize (1 bit).
//    key_zeroize, or rst_sys, clears all 32 file entries and K0..K3 to 0 in one cycle and forces IDLE.
//    key_zeroize has priority over key_start.
//  SM4_KEY_ZEROIZE_EN undefined:
//    No key_zeroize port; the file has no reset and only control state resets.
//    Contents after reset are undefined, but are never flagged valid.
// TESTING
//  T1: key_in=0123456789ABCDEFFEDCBA9876543210, start -> key_done 32 cycles after the start edge;
//      file[0]=F12186F9, file[1]=41662B61, file[31]=9124A012.
//  T2: after T1, rk_decrypt=1, rk_rd_idx=0 -> next cycle rk_out=9124A012, rk_valid=1;
//      rk_rd_idx=31 -> F12186F9.
//  T3: sm4_round_cnt monitor during EXPAND -> exactly 0,1,..,31, then 0;
//      key_busy high for exactly 32 cycles.
//  T4: key_start re-pulsed at cnt=10 with a different key -> ignored; results equal T1.
//  T5: rst_sys at cnt=15 -> IDLE next cycle, key_ready=0; a read returns rk_valid=0;
//      a fresh start then reproduces T1.
//  T6 (SM4_KEY_ZEROIZE_EN): after T1, key_zeroize=1 -> key_ready=0; file all 0;
//      a later start reproduces T1.

Source files
------------

// File: rtl/sm4_key_expand.sv
// sm4_key_expand: iterative SM4 key schedule, one round key per clock, held in a 32x32 file.
// Ports: clk_sys/rst_sys (sync active-high), key_in/key_start load the master key,
// key_busy/key_ready/key_done report progress, sm4_round_cnt/sm4_key_cki talk to the CK table,
// rk_rd_en/rk_rd_idx/rk_decrypt request a registered read on rk_out/rk_valid.
// Optional: SM4_KEY_ZEROIZE_EN adds key_zeroize, which wipes the file and key state in one cycle.
module sm4_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
  // entry a sits at bits [8*(255-a)+7 -: 8], i.e. index {~a, 3'b111}
  assign s_o = SBOX[{~a_i, 3'b111} -: 8];
endmodule

module sm4_key_expand (
  input  logic         clk_sys,
  input  logic         rst_sys,
`ifdef SM4_KEY_ZEROIZE_EN
  input  logic         key_zeroize,
`endif
  input  logic [127:0] key_in,
  input  logic         key_start,
  output logic         key_busy,
  output logic         key_ready,
  output logic         key_done,
  output logic [4:0]   sm4_round_cnt,
  input  logic [31:0]  sm4_key_cki,
  input  logic         rk_rd_en,
  input  logic [4:0]   rk_rd_idx,
  input  logic         rk_decrypt,
  output logic [31:0]  rk_out,
  output logic         rk_valid
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] k_q [4];
  logic [31:0] file_q [32];
  logic [31:0] x, b, rk, rk_out_q;
  logic        rk_valid_q, ctl_rst, clr, start, last;
`ifdef SM4_KEY_ZEROIZE_EN
  assign ctl_rst = rst_sys | key_zeroize;
  assign clr     = ctl_rst;
`else
  // without zeroize the key material carries no reset; only control state does
  assign ctl_rst = rst_sys;
  assign clr     = 1'b0;
`endif
  assign start = key_start && state_q != EXPAND;
  assign last  = state_q == EXPAND && cnt_q == 5'd31;
  assign x     = k_q[1] ^ k_q[2] ^ k_q[3] ^ sm4_key_cki;
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sm4_sbox u_sbox (.a_i(x[8*g +: 8]), .s_o(b[8*g +: 8]));
  end
  assign rk = k_q[0] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  always_comb begin
    state_d = start ? EXPAND : last ? READY : state_q;
    cnt_d   = state_q == EXPAND ? cnt_q + 5'd1 : 5'd0;
    done_d  = last;
  end
  always_ff @(posedge clk_sys) begin
    if (ctl_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      done_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      rk_valid_q <= rk_rd_en && state_q == READY;
      // reads see the file as it stands before this edge, so a read beside key_start gets old keys
      if (rk_rd_en && state_q == READY) rk_out_q <= file_q[rk_decrypt ? ~rk_rd_idx : rk_rd_idx];
    end
  end
  always_ff @(posedge clk_sys) begin
    if (clr) begin
      for (int i = 0; i < 32; i++) file_q[i] <= 32'd0;
      k_q <= '{default: 32'd0};
    end else if (start) begin
      k_q <= '{key_in[127:96] ^ 32'hA3B1BAC6, key_in[95:64] ^ 32'h56AA3350,
               key_in[63:32] ^ 32'h677D9197, key_in[31:0] ^ 32'hB27022DC};
    end else if (state_q == EXPAND) begin
      k_q          <= '{k_q[1], k_q[2], k_q[3], rk};
      file_q[cnt_q] <= rk;
    end
  end
  assign key_busy      = state_q == EXPAND;
  assign key_ready     = state_q == READY;
  assign key_done      = done_q;
  assign sm4_round_cnt = cnt_q;
  assign rk_out        = rk_out_q;
  assign rk_valid      = rk_valid_q;
endmodule

// File: tb/tb_sm4_key_expand.sv
// tb_sm4_key_expand: directed bench for sm4_key_expand against a reference SM4 key-schedule model.
module tb_sm4_key_expand;
  logic         clk_sys = 1'b0, rst_sys = 1'b1, key_start = 1'b0, rk_rd_en = 1'b0, rk_decrypt = 1'b0;
  logic [127:0] key_in = '0;
  logic [4:0]   rk_rd_idx = '0;
  logic [31:0]  sm4_key_cki, rk_out;
  logic [4:0]   sm4_round_cnt;
  logic         key_busy, key_ready, key_done, rk_valid;
`ifdef SM4_KEY_ZEROIZE_EN
  logic         key_zeroize = 1'b0;
`endif
  localparam logic [127:0] MK1 = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] MK2 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [2047:0] SB = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948};
  logic [7:0]  sbt [256];
  logic [31:0] exp_rk [32];
  logic        exp_ready = 1'b0;
  int          total = 0, bad = 0;

  sm4_key_expand dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys),
`ifdef SM4_KEY_ZEROIZE_EN
    .key_zeroize(key_zeroize),
`endif
    .key_in(key_in), .key_start(key_start), .key_busy(key_busy), .key_ready(key_ready),
    .key_done(key_done), .sm4_round_cnt(sm4_round_cnt), .sm4_key_cki(sm4_key_cki),
    .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx), .rk_decrypt(rk_decrypt),
    .rk_out(rk_out), .rk_valid(rk_valid));

  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] ck(input int i);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
    return r;
  endfunction
  assign sm4_key_cki = ck(int'(sm4_round_cnt));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input logic [127:0] mk);
    logic [31:0] k [4];
    logic [31:0] t, b;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6; k[1] = mk[95:64] ^ 32'h56AA3350;
    k[2] = mk[63:32] ^ 32'h677D9197;  k[3] = mk[31:0] ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      t = k[1] ^ k[2] ^ k[3] ^ ck(i);
      b = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
      exp_rk[i] = k[0] ^ b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
      k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = exp_rk[i];
    end
  endtask

  // read checker: every cycle, rk_valid/rk_out must reflect the request seen at the previous edge
  logic        req_q = 1'b0, rdy_q = 1'b0;
  logic [31:0] exp_q = '0;
  always @(posedge clk_sys) begin
    req_q <= rk_rd_en && !rst_sys;
    rdy_q <= exp_ready;
    exp_q <= exp_rk[rk_decrypt ? 5'd31 - rk_rd_idx : rk_rd_idx];
  end
  always @(negedge clk_sys) begin
    chk("rk_valid", 32'(rk_valid), 32'(req_q && rdy_q));
    if (req_q && rdy_q) chk("rk_out", rk_out, exp_q);
  end

  task automatic run_expand(input logic [127:0] mk, input int kick_at, input logic [127:0] kick,
                            input int abort_at, input bit rd);
    int busy_n = 0, done_n = 0, done_at = -1;
    key_in = mk; key_start = 1'b1;
    if (rd) begin rk_rd_en = 1'b1; rk_rd_idx = 5'd5; rk_decrypt = 1'b0; end
    @(posedge clk_sys); #1;
    key_start = 1'b0; rk_rd_en = 1'b0; exp_ready = 1'b0;
    if (rd) chk("rd_with_start", rk_out, exp_rk[5]);
    for (int e = 0; e <= 33; e++) begin
      if (e > 0) begin @(posedge clk_sys); #1; key_start = 1'b0; end
      chk("round_cnt", 32'(sm4_round_cnt), 32'(e <= 31 ? e : 0));
      busy_n += int'(key_busy);
      done_n += int'(key_done);
      if (key_done && done_at < 0) done_at = e;
      if (e == kick_at) begin key_in = kick; key_start = 1'b1; end
      if (e == abort_at) begin
        rst_sys = 1'b1;
        @(posedge clk_sys); #1;
        rst_sys = 1'b0;
        chk("abort_ready", 32'(key_ready), 32'd0);
        chk("abort_busy", 32'(key_busy), 32'd0);
        chk("abort_cnt", 32'(sm4_round_cnt), 32'd0);
        return;
      end
    end
    chk("busy_cycles", 32'(busy_n), 32'd32);
    chk("done_edge", 32'(done_at), 32'd32);
    chk("done_pulses", 32'(done_n), 32'd1);
    chk("ready_after", 32'(key_ready), 32'd1);
    model(mk);
    exp_ready = 1'b1;
  endtask

  task automatic read_all(input bit d);
    for (int i = 0; i < 32; i++) begin
      rk_rd_en = 1'b1; rk_rd_idx = 5'(i); rk_decrypt = d;
      @(posedge clk_sys); #1;
    end
    rk_rd_en = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic read_one(input logic [4:0] idx, input bit d);
    rk_rd_en = 1'b1; rk_rd_idx = idx; rk_decrypt = d;
    @(posedge clk_sys); #1;
    rk_rd_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) sbt[i] = SB[2047 - 8*i -: 8];
    chk("ck0", ck(0), 32'h00070E15);
    chk("ck31", ck(31), 32'h646B7279);
    model(MK1);
    chk("model_rk0", exp_rk[0], 32'hF12186F9);
    chk("model_rk1", exp_rk[1], 32'h41662B61);
    chk("model_rk31", exp_rk[31], 32'h9124A012);
    exp_rk = '{default: 32'd0};
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_busy", 32'(key_busy), 32'd0);
    chk("rst_ready", 32'(key_ready), 32'd0);
    chk("rst_done", 32'(key_done), 32'd0);
    chk("rst_valid", 32'(rk_valid), 32'd0);
    chk("rst_out", rk_out, 32'd0);
    chk("rst_cnt", 32'(sm4_round_cnt), 32'd0);
    rst_sys = 1'b0;
    @(posedge clk_sys); #1;
    run_expand(MK1, -1, '0, -1, 1'b0);
    read_all(1'b0);
    read_all(1'b1);
    read_one(5'd0, 1'b1);
    chk("t2_dec_idx0", rk_out, 32'h9124A012);
    chk("t2_valid", 32'(rk_valid), 32'd1);
    read_one(5'd31, 1'b1);
    chk("t2_dec_idx31", rk_out, 32'hF12186F9);
    read_one(5'd1, 1'b0);
    chk("t1_file1", rk_out, 32'h41662B61);
    run_expand(MK2, -1, '0, -1, 1'b1);
    read_all(1'b0);
    run_expand(MK1, 10, MK2, -1, 1'b0);
    read_all(1'b0);
    read_one(5'd31, 1'b0);
    chk("t4_file31", rk_out, 32'h9124A012);
    run_expand(MK1, -1, '0, 15, 1'b0);
    read_one(5'd0, 1'b0);
    chk("t5_read_invalid", 32'(rk_valid), 32'd0);
    @(posedge clk_sys); #1;
    run_expand(MK1, -1, '0, -1, 1'b0);
    read_all(1'b1);
`ifdef SM4_KEY_ZEROIZE_EN
    key_zeroize = 1'b1; key_start = 1'b1;
    @(posedge clk_sys); #1;
    key_zeroize = 1'b0; key_start = 1'b0; exp_ready = 1'b0;
    chk("t6_ready", 32'(key_ready), 32'd0);
    chk("t6_busy", 32'(key_busy), 32'd0);
    read_one(5'd3, 1'b0);
    chk("t6_read_invalid", 32'(rk_valid), 32'd0);
    run_expand(MK1, -1, '0, -1, 1'b0);
    read_all(1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
